// File: rtl/onewire_scratchpad_rx.sv
// One-wire scratchpad receiver: sequences the bit-read stage byte by byte, assembles LSB-first,
// and decodes DS18B20 fields. Define ONEWIRE_RX_CRC_EN to include the Dallas CRC-8 check.
module onewire_scratchpad_rx #(
  parameter int NUM_BYTES = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        bus_in,
  input  logic        sample,
  input  logic        read_done,
  output logic        read_enable,
  output logic        busy,
  output logic        valid,
  output logic        crc_ok,
  output logic        frame_err,
  output logic [15:0] temp_raw,
  output logic [7:0]  th,
  output logic [7:0]  tl,
  output logic [7:0]  cfg
);

  typedef enum logic [2:0] {IDLE, READ, STORE, GAP, CHECK} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [3:0]  bit_cnt_q;
  logic [3:0]  byte_cnt_q;
  logic [7:0]  shift_q;
  logic        take;
  logic        last_byte;

  assign take        = (state_q == READ) && sample && (bit_cnt_q < 4'd8);
  assign last_byte   = (byte_cnt_q == 4'(NUM_BYTES - 1));
  // Decoded from the async-reset state register so enable drops the instant reset asserts.
  assign read_enable = (state_q == READ);
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (read_done) state_d = STORE;
      STORE:   state_d = last_byte ? CHECK : GAP;
      GAP:     state_d = READ;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], bus_in};
  end

`ifdef ONEWIRE_RX_CRC_EN
  logic [7:0] crc_q;
  logic       crc_fb;

  assign crc_fb = crc_q[0] ^ sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          crc_q <= 8'h00;
    else if ((state_q == IDLE) && start) crc_q <= 8'h00;
    else if (take)                       crc_q <= {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      valid      <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
      temp_raw   <= '0;
      th         <= '0;
      tl         <= '0;
      cfg        <= '0;
    end else begin
      valid <= (state_q == CHECK);
      case (state_q)
        IDLE: begin
          if (start) begin
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            frame_err  <= 1'b0;
            crc_ok     <= 1'b0;
          end
        end
        READ: begin
          if (take) begin
            shift_q   <= {sync_q[1], shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        STORE: begin
          // Bytes past slot 4 only contribute to the CRC.
          case (byte_cnt_q)
            4'd0:    temp_raw[7:0]  <= shift_q;
            4'd1:    temp_raw[15:8] <= shift_q;
            4'd2:    th             <= shift_q;
            4'd3:    tl             <= shift_q;
            4'd4:    cfg            <= shift_q;
            default: ;
          endcase
          if (bit_cnt_q != 4'd8) frame_err <= 1'b1;
          bit_cnt_q <= '0;
          if (!last_byte) byte_cnt_q <= byte_cnt_q + 4'd1;
        end
        CHECK: begin
`ifdef ONEWIRE_RX_CRC_EN
          crc_ok <= (crc_q == 8'h00) && !frame_err;
`else
          crc_ok <= !frame_err;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_scratchpad_rx.sv
// Bench for onewire_scratchpad_rx: table vectors, hand sequences, and random frames vs a bit-stream model.
module tb_onewire_scratchpad_rx;
  localparam int NB = 9;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, bus_in = 1'b1, sample = 1'b0, read_done = 1'b0;
  logic        read_enable, busy, valid, crc_ok, frame_err;
  logic [15:0] temp_raw;
  logic [7:0]  th, tl, cfg;

  onewire_scratchpad_rx #(.NUM_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus_in(bus_in), .sample(sample),
    .read_done(read_done), .read_enable(read_enable), .busy(busy), .valid(valid),
    .crc_ok(crc_ok), .frame_err(frame_err), .temp_raw(temp_raw), .th(th), .tl(tl), .cfg(cfg)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Monitor: read_enable high periods, low runs between them, valid pulses.
  int re_highs = 0, gap_bad = 0, valid_cnt = 0, busy_bad = 0, tail_low = 0, low_run = 99;
  logic prev_re = 1'b0;
  always @(negedge clk) begin
    if (read_enable && !prev_re) begin
      re_highs <= re_highs + 1;
      if (low_run != 99 && low_run != 2) gap_bad <= gap_bad + 1;
    end
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      tail_low  <= low_run;
      if (busy) busy_bad <= busy_bad + 1;
    end
    low_run <= !busy ? 99 : (read_enable ? 0 : low_run + 1);
    prev_re <= read_enable;
  end

  // Model: every accepted bit since reset, CRC over accepted bits since start.
  bit         hist[$];
  logic [7:0] m_crc;
  bit         m_ferr;
  int         m_bcnt;
  logic [7:0] m_slot[5];

  function automatic logic [7:0] crc_bit(logic [7:0] c, bit b);
    return (c >> 1) ^ ((c[0] ^ b) ? 8'h8C : 8'h00);
  endfunction

  function automatic logic [7:0] last8();
    logic [7:0] v;
    for (int j = 0; j < 8; j++) v[j] = hist[hist.size() - 8 + j];
    return v;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < 8; j++) hist.push_back(1'b0);
    for (int j = 0; j < 5; j++) m_slot[j] = 8'h00;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_re();
    int n = 0;
    while (!read_enable && n < 200) begin tick(); n++; end
    if (!read_enable) chk("read_enable_timeout", {31'b0, read_enable}, 32'd1);
  endtask

  task automatic do_sample(input bit b, input bit with_done, input bit with_start, input int nt);
    bus_in = b;
    repeat (nt) tick();
    sample = 1'b1; read_done = with_done; start = with_start;
    tick();
    sample = 1'b0; read_done = 1'b0; start = 1'b0;
    if (m_bcnt < 8) begin
      hist.push_back(b);
      m_crc = crc_bit(m_crc, b);
      m_bcnt++;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int ns, input int idx, input bit kick, input bit rnd);
    bit merge;
    wait_re();
    m_bcnt = 0;
    merge  = rnd && ($urandom_range(0, 1) == 1);
    for (int k = 0; k < ns; k++) begin
      do_sample((k < 8) ? d[k] : 1'b0, merge && (k == ns - 1), kick && (k == 3),
                rnd ? 2 + $urandom_range(0, 3) : 3);
    end
    if (!merge) begin
      read_done = 1'b1; tick(); read_done = 1'b0;
    end
    bus_in = 1'b1;
    if (m_bcnt != 8) m_ferr = 1'b1;
    if (idx < 5) m_slot[idx] = last8();
  endtask

  task automatic run_frame(input logic [NB-1:0][7:0] b, input int sidx, input int sns,
                           input int kick, input bit rnd);
    int h0, g0, v0, b0, n;
    h0 = re_highs; g0 = gap_bad; v0 = valid_cnt; b0 = busy_bad;
    m_crc = 8'h00; m_ferr = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < NB; i++) send_byte(b[i], (i == sidx) ? sns : 8, i, i == kick, rnd);
    n = 0;
    while (!valid && n < 50) begin tick(); n++; end
    chk("valid_seen", {31'b0, valid}, 32'd1);
    chk("busy_in_valid", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    chk("valid_count", valid_cnt - v0, 32'd1);
    chk("re_high_periods", re_highs - h0, NB);
    chk("re_gap_len", gap_bad - g0, 32'd0);
    chk("re_tail_len", tail_low, 32'd2);
    chk("busy_at_valid", busy_bad - b0, 32'd0);
  endtask

  task automatic chk_fields(input logic [15:0] t, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, input bit ok, input bit fe);
    chk("temp_raw", temp_raw, t);
    chk("th", th, h);
    chk("tl", tl, l);
    chk("cfg", cfg, c);
    chk("crc_ok", {31'b0, crc_ok}, {31'b0, ok});
    chk("frame_err", {31'b0, frame_err}, {31'b0, fe});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_re"}, {31'b0, read_enable}, 32'd0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_outs"}, {crc_ok, frame_err, temp_raw, th, tl, cfg}, 32'd0);
  endtask

  typedef struct {
    logic [NB-1:0][7:0] b;
    int sidx, sns, kick;
    logic [15:0] t;
    logic [7:0] h, l, c;
    bit ok, fe;
  } vec_t;

  localparam logic [NB-1:0][7:0] GOOD =
    {8'h1C, 8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, 8'h05, 8'h50};

`ifdef ONEWIRE_RX_CRC_EN
  localparam bit BADCRC_OK = 1'b0;
`else
  localparam bit BADCRC_OK = 1'b1;
`endif

  initial begin
    vec_t tv[5];
    logic [NB-1:0][7:0] fb;
    logic [7:0] c;
    bit ok;

    fb = GOOD; fb[8] = 8'h1D;
    tv[0] = '{GOOD, -1, 8, -1, 16'h0550, 8'h4B, 8'h46, 8'h7F, 1'b1, 1'b0};
    tv[1] = '{fb,   -1, 8, -1, 16'h0550, 8'h4B, 8'h46, 8'h7F, BADCRC_OK, 1'b0};
    // 7 samples of 0x4B land in bits 7:1; bit 0 is left over from byte1 (0x05, msb 0).
    tv[2] = '{GOOD,  2, 7, -1, 16'h0550, 8'h96, 8'h46, 8'h7F, 1'b0, 1'b1};
    tv[3] = '{GOOD,  0, 9, -1, 16'h0550, 8'h4B, 8'h46, 8'h7F, 1'b1, 1'b0};
    tv[4] = '{GOOD, -1, 8,  3, 16'h0550, 8'h4B, 8'h46, 8'h7F, 1'b1, 1'b0};

    model_reset();
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_frame(tv[i].b, tv[i].sidx, tv[i].sns, tv[i].kick, 1'b0);
      chk_fields(tv[i].t, tv[i].h, tv[i].l, tv[i].c, tv[i].ok, tv[i].fe);
    end

    // Reset in the middle of byte 5 must clear everything without a clock edge.
    start = 1'b1; tick(); start = 1'b0;
    m_crc = 8'h00; m_ferr = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(GOOD[i], 8, i, 1'b0, 1'b0);
    wait_re();
    m_bcnt = 0;
    for (int k = 0; k < 4; k++) do_sample(GOOD[5][k], 1'b0, 1'b0, 3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_frame(GOOD, -1, 8, -1, 1'b0);
    chk_fields(16'h0550, 8'h4B, 8'h46, 8'h7F, 1'b1, 1'b0);

    // Random frames against the model; stray strobes while idle must be ignored.
    for (int it = 0; it < 20; it++) begin
      logic [NB-1:0][7:0] rb;
      int sidx, sns;
      for (int k = 0; k < 3; k++) begin
        bus_in = 1'($urandom_range(0, 1));
        repeat (3) tick();
        sample = 1'b1; read_done = 1'($urandom_range(0, 1)); tick();
        sample = 1'b0; read_done = 1'b0;
      end
      bus_in = 1'b1;
      c = 8'h00;
      for (int i = 0; i < NB - 1; i++) begin
        rb[i] = 8'($urandom);
        for (int k = 0; k < 8; k++) c = crc_bit(c, rb[i][k]);
      end
      rb[NB-1] = ($urandom_range(0, 1) == 1) ? c : (c ^ (8'h01 << $urandom_range(0, 7)));
      sidx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : -1;
      sns  = ($urandom_range(0, 1) == 1) ? 7 : 9;
      run_frame(rb, sidx, sns, -1, 1'b1);
`ifdef ONEWIRE_RX_CRC_EN
      ok = (m_crc == 8'h00) && !m_ferr;
`else
      ok = !m_ferr;
`endif
      chk_fields({m_slot[1], m_slot[0]}, m_slot[2], m_slot[3], m_slot[4], ok, m_ferr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/onewire_scratchpad_rx.md
Name: onewire_scratchpad_rx

Overview:
- Downstream consumer and sequencer for the one-wire bit-read stage.
- Per byte: raises that stage's enable, captures the synchronised bus level on each sample strobe, and assembles bits LSB-first.
- Repeats for NUM_BYTES bytes, checks Dallas CRC-8 and presents decoded DS18B20 scratchpad fields to the top-level controller.
- Sits between the one-wire top module (bus pad, command sequencer) and the bit-read stage.

Parameters:
NUM_BYTES, 9, bytes per transaction; legal range 2..15; last byte is the CRC byte.

Ports:
clk  input  1  system clock, 27 MHz
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin a scratchpad read
bus_in  input  1  raw one-wire line level (asynchronous)
sample  input  1  one-cycle strobe from the bit-read stage: capture now
read_done  input  1  bit-read stage finished its 8 samples
read_enable  output  1  enable to the bit-read stage
busy  output  1  transaction in progress
valid  output  1  one-cycle pulse: transaction complete, fields updated
crc_ok  output  1  CRC of last transaction passed
frame_err  output  1  a byte ended with a bit count other than 8
temp_raw  output  16  {byte1, byte0}
th  output  8  byte2
tl  output  8  byte3
cfg  output  8  byte4

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0; bit_cnt, byte_cnt, shift register and crc are 0; sync flops are 1 (idle bus).
- bus_in passes through a 2-flop synchroniser. The captured bit is the synchroniser output in the cycle sample=1 (2-cycle lag, negligible against the 15 us slot).
- States:
  - IDLE: busy=0, read_enable=0. start -> READ; clear byte_cnt, crc, frame_err, crc_ok.
  - READ: read_enable=1, busy=1.
    - On sample with bit_cnt<8: shift_reg <= {bit, shift_reg[7:1]}; bit_cnt++; update crc.
    - Samples with bit_cnt==8 are ignored (no shift, no CRC update).
    - On read_done -> STORE.
  - STORE: 1 cycle, read_enable=0.
    - Write shift_reg into byte slot byte_cnt. Only slots 0..4 are retained; other bytes feed only the CRC.
    - If bit_cnt!=8, set frame_err (sticky until next start).
    - Clear bit_cnt. If byte_cnt==NUM_BYTES-1 -> CHECK, else byte_cnt++ and -> GAP.
  - GAP: read_enable=0 for exactly 1 further cycle, so the read stage sees enable low and clears its done. Then -> READ.
  - CHECK: 1 cycle. crc_ok <= (crc==0) && !frame_err. Pulse valid=1 -> IDLE.
- read_enable low spans 2 cycles between bytes (STORE+GAP), and 1 cycle (STORE) before CHECK.
- CRC-8: polynomial x^8+x^5+x^4+1, reflected constant 0x8C, init 0x00, bit-serial LSB-first.
  - Per bit: fb = crc[0]^bit; crc = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00).
  - After all NUM_BYTES including the CRC byte, a good frame leaves crc==0.
- Output fields temp_raw/th/tl/cfg update only at STORE of their byte. They hold their values while IDLE.
- start while busy: ignored.
- sample or read_done while IDLE: ignored.
- sample and read_done in the same cycle: the sample is captured first, then -> STORE.
- rst_n low mid-transaction: immediate return to IDLE with all outputs cleared; read_enable drops asynchronously.

Optional Feature:
ONEWIRE_RX_CRC_EN
- Defined: CRC register and check as above.
- Undefined: no CRC logic; crc_ok <= !frame_err in CHECK.

Test Plan:
- Reset, then start; model sends 50 05 4B 46 7F FF 0C 10 1C LSB-first, 8 samples per byte -> valid pulses once; temp_raw=0x0550, th=0x4B, tl=0x46, cfg=0x7F, crc_ok=1, frame_err=0, busy falls in the valid cycle.
- Same frame with last byte 0x1D -> valid=1, crc_ok=0 with ONEWIRE_RX_CRC_EN; crc_ok=1 without it.
- Byte 2 delivered with 7 samples before read_done -> frame_err=1, crc_ok=0; remaining bytes still collected, valid pulses.
- Byte 0 with 9 samples (9th bus=0, preceding bits 0x50) -> temp_raw[7:0]=0x50; 9th sample ignored.
- Observe read_enable -> low 2 cycles between bytes, 1 cycle before CHECK; exactly 9 high periods per transaction.
- start pulsed during byte 3 -> ignored. rst_n asserted during byte 5 -> busy=0, read_enable=0, outputs 0 with no clock edge. Fresh start afterwards -> full correct frame.
